// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-read-port register file, registered reads with
//            write bypass, x0 hardwired to zero, sequenced bulk-clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rs_addr,
  input  logic [NREAD-1:0]      rs_en,
  output logic [NREAD*XLEN-1:0] rs_data,
  input  logic                  reg_write,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       data_in,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  wr_dropped
);

  localparam logic [0:0]    c_st_idle  = 1'b0;
  localparam logic [0:0]    c_st_clear = 1'b1;
  localparam logic [AW-1:0] c_last_ptr = AW'(NREGS - 1);

  logic [XLEN-1:0] r_mem [NREGS];
  logic [0:0]      r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_wr_dropped;
  logic            w_busy;
  logic            w_wr_req;
  logic            w_wr_ok;

  assign w_busy     = (r_state == c_st_clear);
  assign w_wr_req   = reg_write && (rd != '0);
  assign w_wr_ok    = w_wr_req && !w_busy;
  assign busy       = w_busy;
  assign wr_dropped = r_wr_dropped;

  // Writes and clear never collide: writes are only accepted while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[rd] <= data_in;
    end else if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (clear_start) begin
            r_state <= c_st_clear;
            r_ptr   <= AW'(1);
          end
        end
        c_st_clear: begin
          if (r_ptr == c_last_ptr) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_dropped <= 1'b0;
    end else begin
      r_wr_dropped <= w_wr_req && w_busy;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] r_q;

    assign w_addr = rs_addr[gi*AW +: AW];

    // Reads during a clear return zero so no half-cleared contents escape.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_q <= '0;
      end else if (rs_en[gi]) begin
        if (w_busy || (w_addr == '0)) begin
          r_q <= '0;
        end else if (reg_write && (rd == w_addr)) begin
          r_q <= data_in;
        end else begin
          r_q <= r_mem[w_addr];
        end
      end
    end

    assign rs_data[gi*XLEN +: XLEN] = r_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed bench for regfile_mp with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: XLEN=32, NREGS=32, NREAD=2
  logic [9:0]  a_addr = '0;
  logic [1:0]  a_en   = '0;
  logic [63:0] a_data;
  logic        a_we   = 1'b0;
  logic [4:0]  a_rd   = '0;
  logic [31:0] a_din  = '0;
  logic        a_cs   = 1'b0;
  logic        a_busy;
  logic        a_drop;

  // Wide instance: XLEN=64, NREGS=16, NREAD=3
  logic [11:0]  b_addr = '0;
  logic [2:0]   b_en   = '0;
  logic [191:0] b_data;
  logic         b_we   = 1'b0;
  logic [3:0]   b_rd   = '0;
  logic [63:0]  b_din  = '0;
  logic         b_cs   = 1'b0;
  logic         b_busy;
  logic         b_drop;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .rs_addr(a_addr), .rs_en(a_en), .rs_data(a_data),
    .reg_write(a_we), .rd(a_rd), .data_in(a_din), .clear_start(a_cs),
    .busy(a_busy), .wr_dropped(a_drop)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_b (
    .clk(clk), .rst(rst), .rs_addr(b_addr), .rs_en(b_en), .rs_data(b_data),
    .reg_write(b_we), .rd(b_rd), .data_in(b_din), .clear_start(b_cs),
    .busy(b_busy), .wr_dropped(b_drop)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model of instance A. A clear is modelled as wiping the whole
  // file at once plus a countdown of busy cycles.
  logic [31:0] m_mem [32];
  logic [31:0] m_q   [2];
  int          m_left;
  bit          m_drop;
  bit          m_busy_now;
  logic [4:0]  m_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_q[0] = '0; m_q[1] = '0;
      m_left = 0;
      m_drop = 1'b0;
    end else begin
      m_busy_now = (m_left > 0);
      for (int p = 0; p < 2; p++) begin
        if (a_en[p]) begin
          m_a = a_addr[p*5 +: 5];
          if (m_busy_now || m_a == 0)      m_q[p] = '0;
          else if (a_we && a_rd == m_a)    m_q[p] = a_din;
          else                             m_q[p] = m_mem[m_a];
        end
      end
      m_drop = a_we && (a_rd != 0) && m_busy_now;
      if (!m_busy_now && a_we && a_rd != 0) m_mem[a_rd] = a_din;
      if (m_busy_now) m_left = m_left - 1;
      else if (a_cs) begin
        m_left = 31;
        for (int i = 1; i < 32; i++) m_mem[i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model rs_data", a_data, {m_q[1], m_q[0]});
      check("model busy", a_busy, m_left > 0);
      check("model wr_dropped", a_drop, m_drop);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int cnt;

  initial begin
    #3 rst = 1'b0;
    #1;
    check("reset rs_data A", a_data, 0);
    check("reset busy A", a_busy, 0);
    check("reset drop A", a_drop, 0);
    check("reset rs_data B", b_data, 0);
    chk_on = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // basic write then read on both ports
    a_we = 1; a_rd = 5; a_din = 32'hDEADBEEF;
    @(negedge clk);
    a_rd = 31; a_din = 32'h12345678;
    @(negedge clk);
    a_we = 0; a_addr = {5'd31, 5'd5}; a_en = 2'b11;
    @(negedge clk);
    check("read x5/x31", a_data, 64'h12345678_DEADBEEF);

    // write to x0 is discarded silently
    a_we = 1; a_rd = 0; a_din = 32'hFFFFFFFF; a_addr = {5'd31, 5'd0}; a_en = 2'b01;
    @(negedge clk);
    check("x0 bypass blocked", a_data[31:0], 0);
    check("x0 write no drop", a_drop, 0);
    a_we = 0;
    @(negedge clk);
    check("x0 reads zero", a_data[31:0], 0);

    // bypass on both ports, then hold
    a_we = 1; a_rd = 7; a_din = 32'hA5A5A5A5; a_addr = {5'd7, 5'd7}; a_en = 2'b11;
    @(negedge clk);
    check("bypass x7 both", a_data, 64'hA5A5A5A5_A5A5A5A5);
    a_we = 0; a_en = 2'b00; a_addr = {5'd2, 5'd1};
    @(negedge clk);
    check("hold when disabled", a_data, 64'hA5A5A5A5_A5A5A5A5);

    // fill x1..x31
    for (int i = 1; i < 32; i++) begin
      a_we = 1; a_rd = 5'(i); a_din = 32'h10000000 + i;
      @(negedge clk);
    end
    a_we = 0; a_addr = {5'd2, 5'd1}; a_en = 2'b11;
    @(negedge clk);
    check("filled x1/x2", a_data, 64'h10000002_10000001);
    a_en = 2'b00;

    // bulk clear with a dropped write and an ignored restart
    a_cs = 1;
    @(negedge clk);
    a_cs = 0;
    cnt = 0;
    while (a_busy && cnt < 100) begin
      cnt++;
      if (cnt == 6) check("drop pulse", a_drop, 1);
      if (cnt == 7) check("drop clears", a_drop, 0);
      a_we = (cnt == 5); a_rd = 3; a_din = 32'h55;
      a_cs = (cnt == 10);
      @(negedge clk);
    end
    a_cs = 0;
    check("busy length 31", cnt, 31);
    a_we = 1; a_rd = 9; a_din = 32'h99; a_addr = {5'd9, 5'd0}; a_en = 2'b10;
    @(negedge clk);
    check("write after busy", a_data[63:32], 32'h99);
    a_we = 0;
    for (int i = 1; i < 32; i++) begin
      a_addr = {5'(32 - i), 5'(i)}; a_en = 2'b11;
      @(negedge clk);
      if (i == 3) check("x3 cleared", a_data[31:0], 0);
    end

    // async reset in the middle of a clear
    a_we = 1; a_rd = 1; a_din = 32'h11;
    @(negedge clk);
    a_rd = 2; a_din = 32'h22;
    @(negedge clk);
    a_we = 0; a_addr = {5'd2, 5'd1}; a_en = 2'b11;
    @(negedge clk);
    check("pre-reset read", a_data, 64'h00000022_00000011);
    a_en = 2'b00;
    a_cs = 1; a_we = 1; a_rd = 4; a_din = 32'h44;
    @(negedge clk);
    a_cs = 0; a_we = 0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst busy", a_busy, 0);
    check("async rst rs_data", a_data, 0);
    check("async rst rs_data B", b_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    a_cs = 1;
    @(negedge clk);
    a_cs = 0;
    cnt = 0;
    while (a_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy length after rst", cnt, 31);
    a_addr = {5'd1, 5'd4}; a_en = 2'b11;
    @(negedge clk);
    check("x4/x1 zero", a_data, 0);
    a_en = 2'b00;

    // wide instance
    b_we = 1; b_rd = 15; b_din = 64'h0123456789ABCDEF;
    @(negedge clk);
    b_we = 0; b_addr = {4'd15, 4'd15, 4'd15}; b_en = 3'b111;
    @(negedge clk);
    check("B port0 x15", b_data[63:0], 64'h0123456789ABCDEF);
    check("B port1 x15", b_data[127:64], 64'h0123456789ABCDEF);
    check("B port2 x15", b_data[191:128], 64'h0123456789ABCDEF);
    b_en = 3'b000;
    b_cs = 1;
    @(negedge clk);
    b_cs = 0;
    cnt = 0;
    while (b_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("B busy length 15", cnt, 15);
    b_en = 3'b100;
    @(negedge clk);
    check("B x15 cleared", b_data[191:128], 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the integer register file for the core datapath.
- Generalises data width, register count and number of read ports.
- Read data is registered: one-cycle latency, with write-to-read bypass; x0 is hardwired to zero.
- Adds a sequenced bulk-clear engine with a busy flag, and reports writes dropped while busy.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, >= 4; register 0 is hardwired zero
NREAD, 2, number of independent read ports, >= 1
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
rs_addr  input  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
rs_en  input  NREAD  per-port read enable
rs_data  output  NREAD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN]
reg_write  input  1  write enable
rd  input  AW  write address
data_in  input  XLEN  write data
clear_start  input  1  request a bulk clear of registers 1..NREGS-1
busy  output  1  high while the clear engine runs
wr_dropped  output  1  one-cycle pulse: a write with rd!=0 was discarded because busy was high

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers = 0, all rs_data = 0, busy = 0, wr_dropped = 0.
  - FSM goes to IDLE and the clear pointer = 0.
  - Takes effect immediately, including mid-clear.
  - Deassertion is sampled at the next rising edge.
- Write:
  - At the edge, if reg_write=1, rd!=0 and busy=0, then mem[rd] <= data_in.
  - rd=0 writes are silently discarded: no state change, no wr_dropped.
- Read, per port i at each edge:
  - If rs_en[i]=0, rs_data[i] holds its value.
  - If rs_en[i]=1, rs_data[i] <= value, where value is chosen in this priority:
    - busy=1 -> 0
    - rs_addr[i]=0 -> 0
    - reg_write=1 and rd=rs_addr[i] (write accepted this cycle) -> data_in (bypass)
    - otherwise -> mem[rs_addr[i]]
  - Latency: address presented in cycle N, data visible after edge N.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Clear FSM states: IDLE, CLEAR.
  - IDLE: clear_start=1 at an edge -> CLEAR, ptr <= 1, busy <= 1.
  - CLEAR: each edge does mem[ptr] <= 0, ptr <= ptr+1.
    - When ptr = NREGS-1, that register is zeroed, then -> IDLE and busy <= 0.
  - busy is therefore high for exactly NREGS-1 cycles.
  - clear_start while busy=1 is ignored (no restart, no extension).
  - The first cycle after busy falls accepts writes and reads normally.
- wr_dropped:
  - Registered; set at the edge where reg_write=1, rd!=0 and busy=1; cleared at the next edge unless the condition repeats.
  - A write coincident with the clear_start edge (busy still 0) is accepted, then overwritten by the clear.
- Reads never modify state.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset with all defaults, then write x5=0xDEADBEEF and x31=0x12345678; read port0=5, port1=31 next cycle -> rs_data after one edge = 0xDEADBEEF / 0x12345678.
- Write rd=0 data 0xFFFFFFFF with port0 reading x0 the same cycle -> rs_data0=0, wr_dropped=0, x0 still reads 0.
- Bypass: write x7=0xA5A5A5A5 and read x7 on both ports in the same cycle -> both ports = 0xA5A5A5A5 after one edge; rs_en=0 on the next cycle -> outputs hold.
- Fill x1..x31 with nonzero values, pulse clear_start -> busy high for 31 cycles.
  - Write x3=0x55 during busy -> wr_dropped pulses one cycle.
  - After busy falls, reads of x1..x31 all = 0.
- Assert rst=0 asynchronously mid-clear (cycle 10 of 31) -> busy=0 and rs_data=0 immediately without a clock edge.
  - After release, a clear_start re-runs the full 31 cycles.
- Instance with XLEN=64, NREGS=16, NREAD=3: write x15=0x0123456789ABCDEF and read it on all three ports -> all equal; busy lasts 15 cycles on clear.
